counter_updown_sync: RTL



---
 rtl/counter_updown_sync.sv | 89 ++++++++
 1 files changed

// File: rtl/counter_updown_sync.sv
// Synchronous parametrised up/down counter with wrap or saturate at the range ends,
// a sticky overflow/underflow flag and active-low terminal-count outputs that
// cascade straight into the count strobes of the next stage.
//
// Ports:
//   clk   in   system clock, all state updates on the rising edge
//   reset in   synchronous active-high reset (q=0, ovf=0)
//   clr   in   synchronous clear, active high (q=0, ovf=0)
//   npl   in   synchronous parallel load, active low (q=p clamped to MAX)
//   p     in   parallel load value, only looked at while npl=0
//   ncu   in   count-up request, active low
//   ncd   in   count-down request, active low
//   q     out  registered counter value, range 0..MODULUS-1
//   ntcu  out  terminal count up, active low, combinational
//   ntcd  out  terminal count down, active low, combinational
//   ovf   out  sticky wrap/saturation event flag, registered
module counter_updown_sync #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             npl,
  input  logic [WIDTH-1:0] p,
  input  logic             ncu,
  input  logic             ncd,
  output logic [WIDTH-1:0] q,
  output logic             ntcu,
  output logic             ntcd,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] Max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             up, dn, at_max, at_min, busy;

  // Exactly one strobe asserted means a count; both or neither means hold.
  assign up     = ~ncu & ncd;
  assign dn     = ncu & ~ncd;
  assign at_max = (count_q == Max);
  assign at_min = (count_q == '0);
  // A clear, load or reset in progress must not let a cascaded stage step.
  assign busy   = reset | clr | ~npl;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (!npl) begin
      count_d = (p > Max) ? Max : p;
    end else if (up) begin
      if (at_max) begin
        ovf_d = 1'b1;
        if (!SATURATE) count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dn) begin
      if (at_min) begin
        ovf_d = 1'b1;
        if (!SATURATE) count_d = Max;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = count_q;
  assign ovf  = ovf_q;
  assign ntcu = ~(at_max & up & ~busy);
  assign ntcd = ~(at_min & dn & ~busy);

endmodule
